pc_fetch_unit: RTL and testbench

Program-counter and fetch stage that sits directly upstream of the instruction memory (instr_fetch). It drives the 15-bit word address and captures the returned 32-bit instruction into an IF/ID pipeline register for the decoder. It handles stall, redirect/flush from execute, and halt detection through a small state machine.

---
 rtl/pc_fetch_unit_if.sv | 38 +++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-stage bus bundling the instruction-memory port, pipeline control and IF/ID outputs.
// master (fetch unit): drives imem_addr, id_instr, id_pc, id_valid, halted (and perf_* with FETCH_PERF_CNT_EN);
//   samples imem_instr, stall, redirect_valid, redirect_target.
// slave (memory/decoder/execute side): the mirror image.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic              id_valid;
    logic              halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_bubbles;
    modport master (
        output imem_addr, id_instr, id_pc, id_valid, halted, perf_fetched, perf_bubbles,
        input  imem_instr, stall, redirect_valid, redirect_target
    );
    modport slave (
        input  imem_addr, id_instr, id_pc, id_valid, halted, perf_fetched, perf_bubbles,
        output imem_instr, stall, redirect_valid, redirect_target
    );
`else
    modport master (
        output imem_addr, id_instr, id_pc, id_valid, halted,
        input  imem_instr, stall, redirect_valid, redirect_target
    );
    modport slave (
        input  imem_addr, id_instr, id_pc, id_valid, halted,
        output imem_instr, stall, redirect_valid, redirect_target
    );
`endif
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch stage feeding the IF/ID register, with stall, redirect/flush and halt.
// Ports: clk, rst (async active-high); bus (pc_fetch_unit_if.master):
//   imem_addr = PC register, imem_instr = combinational memory read data,
//   stall / redirect_valid / redirect_target from downstream, id_instr / id_pc / id_valid = IF/ID register,
//   halted = registered HALT indication.
// Optional macro FETCH_PERF_CNT_EN adds bus.perf_fetched and bus.perf_bubbles counters.
module pc_fetch_unit #(
    parameter int               ADDR_W     = 15,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]      HALT_INSTR = 32'hFFFF_FFFF
) (
    input logic           clk,
    input logic           rst,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic              id_valid;
    logic              halted;
    logic              is_halt;
    logic              fetch_en;
    logic              bubble;

    assign is_halt  = bus.imem_instr == HALT_INSTR;
    // redirect beats stall, stall beats halt detection
    assign fetch_en = state == RUN && !bus.redirect_valid && !bus.stall && !is_halt;
    assign bubble   = state == RUN && (bus.redirect_valid || bus.stall);

    assign bus.imem_addr = pc;
    assign bus.id_instr  = id_instr;
    assign bus.id_pc     = id_pc;
    assign bus.id_valid  = id_valid;
    assign bus.halted    = halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            id_instr <= '0;
            id_pc    <= '0;
            id_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    if (bus.redirect_valid) pc <= bus.redirect_target;
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        pc       <= bus.redirect_target;
                        id_valid <= 1'b0;
                    end else if (bus.stall) begin
                        id_valid <= id_valid;
                    end else if (is_halt) begin
                        // the halt word is never issued; pc stays on it
                        id_valid <= 1'b0;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        id_instr <= bus.imem_instr;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(1);
                    end
                end
                HALT: begin
                    // a redirect rescues a halt fetched down a mispredicted path
                    if (bus.redirect_valid) begin
                        pc     <= bus.redirect_target;
                        halted <= 1'b0;
                        state  <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    assign bus.perf_fetched = perf_fetched;
    assign bus.perf_bubbles = perf_bubbles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fetch_en) perf_fetched <= perf_fetched + 32'd1;
            if (bubble)   perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = fetch_en ^ bubble;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven scoreboard bench for pc_fetch_unit plus hand sequences for async reset, boot redirect, wrap and perf counters.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] mem [0:32767];

    pc_fetch_unit_if #(.ADDR_W(15)) bus ();
    pc_fetch_unit_if #(.ADDR_W(15)) bus2 ();

    pc_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
    pc_fetch_unit #(.RESET_PC(15'h7FFE)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    assign bus.imem_instr  = mem[bus.imem_addr];
    assign bus2.imem_instr = mem[bus2.imem_addr];

    typedef struct {
        logic        st;
        logic        rv;
        logic [14:0] rt;
        logic        h4;
        logic [14:0] e_addr;
        logic        e_v;
        logic [14:0] e_pc;
        logic [31:0] e_instr;
        logic        e_h;
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        logic        v;
        logic [14:0] pc;
        logic [31:0] instr;
        logic        h;
    } exp_t;

    vec_t tbl [20];
    exp_t sb [$];
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] w(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic st, input logic rv, input logic [14:0] rt, input logic h4,
                                input logic [14:0] ea, input logic ev, input logic [14:0] ep,
                                input logic [31:0] ei, input logic eh);
        vec_t r;
        r.st = st; r.rv = rv; r.rt = rt; r.h4 = h4;
        r.e_addr = ea; r.e_v = ev; r.e_pc = ep; r.e_instr = ei; r.e_h = eh;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb imem_addr", 32'(bus.imem_addr), 32'(e.addr));
            chk("sb id_valid", 32'(bus.id_valid), 32'(e.v));
            chk("sb halted", 32'(bus.halted), 32'(e.h));
            if (e.v) begin
                chk("sb id_pc", 32'(bus.id_pc), 32'(e.pc));
                chk("sb id_instr", bus.id_instr, e.instr);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = w(i);
        mem[0] = 32'h3C01_0001;
        mem[1] = 32'h0000_0001;
        mem[2] = 32'h0000_0002;
        mem[3] = 32'h0000_0003;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
        bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_target = '0;

        //          st rv rt      h4 addr    v  pc      instr          h
        tbl[0]  = mk(0, 0, 15'd0,  0, 15'd0,  0, 15'd0,  32'h0,         0);
        tbl[1]  = mk(0, 0, 15'd0,  0, 15'd1,  1, 15'd0,  32'h3C01_0001, 0);
        tbl[2]  = mk(0, 0, 15'd0,  0, 15'd2,  1, 15'd1,  32'h1,         0);
        tbl[3]  = mk(1, 0, 15'd0,  0, 15'd2,  1, 15'd1,  32'h1,         0);
        tbl[4]  = mk(1, 0, 15'd0,  0, 15'd2,  1, 15'd1,  32'h1,         0);
        tbl[5]  = mk(1, 0, 15'd0,  0, 15'd2,  1, 15'd1,  32'h1,         0);
        tbl[6]  = mk(0, 0, 15'd0,  0, 15'd3,  1, 15'd2,  32'h2,         0);
        tbl[7]  = mk(0, 0, 15'd0,  0, 15'd4,  1, 15'd3,  32'h3,         0);
        tbl[8]  = mk(0, 0, 15'd0,  0, 15'd5,  1, 15'd4,  32'h1000_0004, 0);
        tbl[9]  = mk(1, 1, 15'd20, 0, 15'd20, 0, 15'd0,  32'h0,         0);
        tbl[10] = mk(0, 0, 15'd0,  0, 15'd21, 1, 15'd20, 32'h1000_0014, 0);
        tbl[11] = mk(0, 1, 15'd3,  1, 15'd3,  0, 15'd0,  32'h0,         0);
        tbl[12] = mk(0, 0, 15'd0,  1, 15'd4,  1, 15'd3,  32'h3,         0);
        tbl[13] = mk(0, 0, 15'd0,  1, 15'd4,  0, 15'd0,  32'h0,         1);
        tbl[14] = mk(0, 0, 15'd0,  1, 15'd4,  0, 15'd0,  32'h0,         1);
        tbl[15] = mk(1, 0, 15'd0,  1, 15'd4,  0, 15'd0,  32'h0,         1);
        tbl[16] = mk(0, 1, 15'd0,  1, 15'd0,  0, 15'd0,  32'h0,         0);
        tbl[17] = mk(0, 0, 15'd0,  1, 15'd1,  1, 15'd0,  32'h3C01_0001, 0);
        tbl[18] = mk(0, 1, 15'd1,  1, 15'd1,  0, 15'd0,  32'h0,         0);
        tbl[19] = mk(0, 0, 15'd0,  1, 15'd2,  1, 15'd1,  32'h1,         0);

        repeat (2) @(negedge clk);
        chk("reset imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("reset id_valid", 32'(bus.id_valid), 32'd0);
        chk("reset id_pc", 32'(bus.id_pc), 32'd0);
        chk("reset id_instr", bus.id_instr, 32'd0);
        chk("reset halted", 32'(bus.halted), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            exp_t e;
            mem[4] = tbl[i].h4 ? 32'hFFFF_FFFF : w(4);
            bus.stall = tbl[i].st;
            bus.redirect_valid = tbl[i].rv;
            bus.redirect_target = tbl[i].rt;
            e.addr = tbl[i].e_addr; e.v = tbl[i].e_v; e.pc = tbl[i].e_pc;
            e.instr = tbl[i].e_instr; e.h = tbl[i].e_h;
            sb.push_back(e);
            @(negedge clk);
        end
        bus.stall = 1'b0; bus.redirect_valid = 1'b0;

        // async reset while halted
        bus.redirect_valid = 1'b1; bus.redirect_target = 15'd4;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("halt entered", 32'(bus.halted), 32'd1);
        chk("halt addr frozen", 32'(bus.imem_addr), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("async rst halted", 32'(bus.halted), 32'd0);
        chk("async rst addr", 32'(bus.imem_addr), 32'd0);
        chk("async rst id_valid", 32'(bus.id_valid), 32'd0);
        chk("async rst id_instr", bus.id_instr, 32'd0);

        // redirect taken in BOOT
        @(negedge clk);
        rst = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 15'd7;
        @(posedge clk); #1;
        chk("boot redirect addr", 32'(bus.imem_addr), 32'd7);
        chk("boot redirect id_valid", 32'(bus.id_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(posedge clk); #1;
        chk("boot redirect id_valid2", 32'(bus.id_valid), 32'd1);
        chk("boot redirect id_pc", 32'(bus.id_pc), 32'd7);
        chk("boot redirect id_instr", bus.id_instr, w(7));

        // async reset while stalled
        @(negedge clk);
        bus.stall = 1'b1;
        @(negedge clk);
        chk("stall hold id_pc", 32'(bus.id_pc), 32'd7);
        chk("stall hold addr", 32'(bus.imem_addr), 32'd8);
        #2 rst = 1'b1;
        #1;
        chk("stall rst id_valid", 32'(bus.id_valid), 32'd0);
        chk("stall rst addr", 32'(bus.imem_addr), 32'd0);
        chk("stall rst id_pc", 32'(bus.id_pc), 32'd0);
        @(negedge clk);
        bus.stall = 1'b0;

`ifdef FETCH_PERF_CNT_EN
        mem[4] = w(4);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bus.stall = 1'b1;
        repeat (2) @(negedge clk);
        bus.stall = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 15'd0;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("perf_fetched", bus.perf_fetched, 32'd4);
        chk("perf_bubbles", bus.perf_bubbles, 32'd3);
        rst = 1'b1;
        #1;
        chk("perf rst fetched", bus.perf_fetched, 32'd0);
        @(negedge clk);
`endif

        // PC wrap from a non-zero reset address
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap boot addr", 32'(bus2.imem_addr), 32'h7FFE);
        chk("wrap boot id_valid", 32'(bus2.id_valid), 32'd0);
        @(posedge clk); #1;
        chk("wrap id_pc 7FFE", 32'(bus2.id_pc), 32'h7FFE);
        chk("wrap id_instr 7FFE", bus2.id_instr, w(15'h7FFE));
        @(posedge clk); #1;
        chk("wrap id_pc 7FFF", 32'(bus2.id_pc), 32'h7FFF);
        chk("wrap addr 0", 32'(bus2.imem_addr), 32'd0);
        @(posedge clk); #1;
        chk("wrap id_pc 0", 32'(bus2.id_pc), 32'd0);
        chk("wrap id_instr 0", bus2.id_instr, 32'h3C01_0001);
        chk("wrap id_valid", 32'(bus2.id_valid), 32'd1);
        @(negedge clk);
        #2 rst2 = 1'b1;
        #1;
        chk("wrap rst id_valid", 32'(bus2.id_valid), 32'd0);
        chk("wrap rst addr", 32'(bus2.imem_addr), 32'h7FFE);
        chk("wrap rst id_instr", bus2.id_instr, 32'd0);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
